tri_normal: RTL and testbench

Iterative unit-normal generator directly upstream of the brightness stage; its tnorm output feeds brightness.tnorm unchanged.
- Accepts one triangle (three vertices, signed fixed point), forms the edges and their cross product, and takes an iterative integer square root of the squared length.
- Performs three parallel restoring divides to produce the unit normal.
- Uses valid/ready handshakes on both sides and handles one triangle at a time.

---
 rtl/tri_normal.sv | 205 ++++++++++++++++++++
 tb/tb_tri_normal.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tri_normal.sv
// Unit-normal generator: edges, cross product, bit-serial integer sqrt of the
// squared length, then three bit-serial restoring divides. One triangle at a time.
module tri_normal #(
  parameter int TOTAL_PREC = 27,
  parameter int FRAC_BITS  = 22
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0][TOTAL_PREC-1:0] v0,
  input  logic [2:0][TOTAL_PREC-1:0] v1,
  input  logic [2:0][TOTAL_PREC-1:0] v2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0][TOTAL_PREC-1:0] tnorm,
  output logic                       degenerate
);

  localparam int TP  = TOTAL_PREC;
  localparam int WW  = 2 * TP + 1;
  localparam int L2W = 2 * TP;
  localparam int RW  = TP + 1;
  localparam int QW  = FRAC_BITS + 1;
  localparam int CW  = $clog2(TP);

  typedef logic signed [TP-1:0] samp_t;
  typedef logic signed [WW-1:0] wide_t;
  typedef enum logic [2:0] {IDLE, EDGE, CROSS, LEN2, SQRT, DIV, DONE} state_t;

  localparam wide_t SAT_MAX = wide_t'((64'sd1 <<< (TP - 1)) - 64'sd1);
  localparam wide_t SAT_MIN = -SAT_MAX - wide_t'(1);

  function automatic samp_t sat(input wide_t x);
    if (x > SAT_MAX)      sat = SAT_MAX[TP-1:0];
    else if (x < SAT_MIN) sat = SAT_MIN[TP-1:0];
    else                  sat = x[TP-1:0];
  endfunction

  function automatic wide_t cross_term(input samp_t a, input samp_t b,
                                       input samp_t c, input samp_t d);
    cross_term = (wide_t'(a) * wide_t'(b) - wide_t'(c) * wide_t'(d)) >>> FRAC_BITS;
  endfunction

  function automatic logic [L2W-1:0] sq(input logic [TP-1:0] x);
    sq = L2W'(x) * L2W'(x);
  endfunction

  state_t state, state_nx;
  logic [CW-1:0] cnt;

  samp_t vr0 [3];
  samp_t vr1 [3];
  samp_t vr2 [3];
  samp_t e1 [3];
  samp_t e2 [3];
  samp_t n [3];
  samp_t e1_c [3];
  samp_t e2_c [3];
  samp_t n_c [3];
  samp_t tn [3];
  logic [TP-1:0] nabs [3];
  logic [L2W-1:0] len2_c;

  logic [L2W-1:0] rad;
  logic [RW-1:0]  rem;
  logic [TP-1:0]  root;
  logic [RW+1:0]  rem_sh;
  logic [RW+1:0]  trial;
  logic           sq_ge;
  logic [RW-1:0]  rem_nx;
  logic [TP-1:0]  root_nx;

  logic [RW-1:0]   r [3];
  logic [QW-2:0]   q [3];
  logic            dge [3];
  logic [TP-1:0]   dsub [3];
  logic [RW-1:0]   r_nx [3];
  logic [QW-1:0]   q_nx [3];
  logic [TP-1:0]   mag [3];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      e1_c[i] = sat(wide_t'(vr1[i]) - wide_t'(vr0[i]));
      e2_c[i] = sat(wide_t'(vr2[i]) - wide_t'(vr0[i]));
      nabs[i] = n[i][TP-1] ? $unsigned(-n[i]) : $unsigned(n[i]);
    end
    n_c[0] = sat(cross_term(e1[1], e2[2], e1[2], e2[1]));
    n_c[1] = sat(cross_term(e1[2], e2[0], e1[0], e2[2]));
    n_c[2] = sat(cross_term(e1[0], e2[1], e1[1], e2[0]));
    len2_c = sq(nabs[0]) + sq(nabs[1]) + sq(nabs[2]);

    // Restoring sqrt step: bring down two radicand bits, try (4*root + 1).
    rem_sh  = {rem, rad[L2W-1 -: 2]};
    trial   = {1'b0, root, 2'b01};
    sq_ge   = (rem_sh >= trial);
    rem_nx  = sq_ge ? (rem_sh[RW-1:0] - trial[RW-1:0]) : rem_sh[RW-1:0];
    root_nx = {root[TP-2:0], sq_ge};

    // Restoring divide step; the dividend's low FRAC_BITS bits are all zero.
    for (int i = 0; i < 3; i++) begin
      dge[i]  = (r[i] >= {1'b0, root});
      dsub[i] = r[i][TP-1:0] - root;
      r_nx[i] = dge[i] ? {dsub[i], 1'b0} : {r[i][TP-1:0], 1'b0};
      q_nx[i] = {q[i], dge[i]};
      mag[i]  = {{(TP-QW){1'b0}}, q_nx[i]};
      tn[i]   = n[i][TP-1] ? -$signed(mag[i]) : $signed(mag[i]);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (in_valid) state_nx = EDGE;
      EDGE:  state_nx = CROSS;
      CROSS: state_nx = LEN2;
      LEN2:  state_nx = (len2_c == '0) ? DONE : SQRT;
      SQRT:  if (cnt == '0) state_nx = DIV;
      DIV:   if (cnt == '0) state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      rad        <= '0;
      rem        <= '0;
      root       <= '0;
      tnorm      <= '0;
      degenerate <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        vr0[i] <= '0;
        vr1[i] <= '0;
        vr2[i] <= '0;
        e1[i]  <= '0;
        e2[i]  <= '0;
        n[i]   <= '0;
        r[i]   <= '0;
        q[i]   <= '0;
      end
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          for (int i = 0; i < 3; i++) begin
            vr0[i] <= v0[i];
            vr1[i] <= v1[i];
            vr2[i] <= v2[i];
          end
        end
        EDGE: begin
          e1 <= e1_c;
          e2 <= e2_c;
        end
        CROSS: n <= n_c;
        LEN2: begin
          rad  <= len2_c;
          rem  <= '0;
          root <= '0;
          cnt  <= CW'(TP - 1);
          if (len2_c == '0) begin
            tnorm      <= '0;
            degenerate <= 1'b1;
          end
        end
        SQRT: begin
          rad  <= {rad[L2W-3:0], 2'b00};
          rem  <= rem_nx;
          root <= root_nx;
          if (cnt == '0) begin
            cnt <= CW'(FRAC_BITS);
            for (int i = 0; i < 3; i++) begin
              r[i] <= {1'b0, nabs[i]};
              q[i] <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          cnt <= cnt - 1'b1;
          for (int i = 0; i < 3; i++) begin
            r[i] <= r_nx[i];
            q[i] <= q_nx[i][QW-2:0];
          end
          if (cnt == '0) begin
            for (int i = 0; i < 3; i++) tnorm[i] <= tn[i];
            degenerate <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_normal.sv
// Bench for tri_normal: directed cases plus random triangles against an
// arithmetic reference of the normal/length/divide rules.
module tb_tri_normal;

  localparam int TP = 27;
  localparam int FB = 22;
  localparam longint ONE = longint'(1) << FB;

  typedef longint vec_t [3];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic out_valid;
  logic out_ready = 1'b0;
  logic degenerate;
  logic [2:0][TP-1:0] v0, v1, v2, tnorm;

  int checks = 0;
  int errors = 0;

  vec_t a, b, c, last_t;
  bit last_dg;
  int lat;
  longint held;

  tri_normal #(.TOTAL_PREC(TP), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .v0(v0), .v1(v1), .v2(v2), .out_valid(out_valid), .out_ready(out_ready),
    .tnorm(tnorm), .degenerate(degenerate)
  );

  always #5 clk = ~clk;

  function automatic longint sat(input longint x);
    longint hi = (longint'(1) << (TP - 1)) - 1;
    longint lo = -(longint'(1) << (TP - 1));
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  function automatic void model(input vec_t p0, input vec_t p1, input vec_t p2,
                                output vec_t t, output bit dg, output longint len);
    vec_t e1, e2, n;
    longint l2, m;
    for (int i = 0; i < 3; i++) begin
      e1[i] = sat(p1[i] - p0[i]);
      e2[i] = sat(p2[i] - p0[i]);
    end
    n[0] = sat((e1[1] * e2[2] - e1[2] * e2[1]) >>> FB);
    n[1] = sat((e1[2] * e2[0] - e1[0] * e2[2]) >>> FB);
    n[2] = sat((e1[0] * e2[1] - e1[1] * e2[0]) >>> FB);
    l2 = n[0] * n[0] + n[1] * n[1] + n[2] * n[2];
    dg = (l2 == 0);
    len = 0;
    t = '{0, 0, 0};
    if (!dg) begin
      len = longint'($floor($sqrt(real'(l2))));
      while (len * len > l2) len--;
      while ((len + 1) * (len + 1) <= l2) len++;
      for (int i = 0; i < 3; i++) begin
        m = (((n[i] < 0) ? -n[i] : n[i]) << FB) / len;
        t[i] = (n[i] < 0) ? -m : m;
      end
    end
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint comp(input int i);
    return longint'($signed(tnorm[i]));
  endfunction

  task automatic accept(input vec_t p0, input vec_t p1, input vec_t p2);
    int w = 0;
    for (int i = 0; i < 3; i++) begin
      v0[i] = TP'(p0[i]);
      v1[i] = TP'(p1[i]);
      v2[i] = TP'(p2[i]);
    end
    in_valid = 1'b1;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs after acceptance; the result must not depend on them.
    for (int i = 0; i < 3; i++) begin
      v0[i] = TP'($urandom);
      v1[i] = TP'($urandom);
      v2[i] = TP'($urandom);
    end
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 200) begin
      @(posedge clk); #1; cycles++;
    end
  endtask

  task automatic run_tri(input string tag, input vec_t p0, input vec_t p1, input vec_t p2);
    vec_t t;
    bit dg;
    longint len, s, d;
    int lt;
    model(p0, p1, p2, t, dg, len);
    accept(p0, p1, p2);
    wait_out(lt);
    check({tag, "_latency"}, lt, dg ? 3 : 53);
    for (int i = 0; i < 3; i++) check($sformatf("%s_tnorm%0d", tag, i), comp(i), t[i]);
    check({tag, "_degenerate"}, longint'(degenerate), longint'(dg));
    if (!dg && len >= (longint'(1) << 21)) begin
      s = comp(0) * comp(0) + comp(1) * comp(1) + comp(2) * comp(2);
      d = s - (longint'(1) << (2 * FB));
      if (d < 0) d = -d;
      check({tag, "_unit_norm"}, longint'(d <= (longint'(1) << (2 * FB - 18))), 1);
    end
    last_t = t;
    last_dg = dg;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_hs_out_valid"}, longint'(out_valid), 0);
    check({tag, "_hs_in_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      v0[i] = '0;
      v1[i] = '0;
      v2[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", longint'(in_ready), 1);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_degenerate", longint'(degenerate), 0);
    for (int i = 0; i < 3; i++) check($sformatf("reset_tnorm%0d", i), comp(i), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Right triangle in the xy plane: normal is +z.
    a = '{0, 0, 0}; b = '{2 * ONE, 0, 0}; c = '{0, 2 * ONE, 0};
    run_tri("t1", a, b, c);
    check("t1_const_z", comp(2), 64'h400000);
    handshake("t1");

    // n = (0,-4,3), len = 5.0.
    a = '{0, 0, 0}; b = '{ONE, 0, 0}; c = '{0, 3 * ONE, 4 * ONE};
    run_tri("t2", a, b, c);
    check("t2_const_y", comp(1), -3355443);
    check("t2_const_z", comp(2), 2516582);
    handshake("t2");

    // Coincident vertices.
    a = '{0, 0, 0}; b = '{ONE, ONE, ONE}; c = '{ONE, ONE, ONE};
    run_tri("t3", a, b, c);
    check("t3_const_deg", longint'(degenerate), 1);
    handshake("t3");

    // Backpressure: result must hold while new requests are ignored.
    a = '{0, 0, 0}; b = '{ONE, 0, 0}; c = '{0, 3 * ONE, 4 * ONE};
    run_tri("bp", a, b, c);
    held = comp(1);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) v1[i] = TP'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", longint'(out_valid), 1);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_tnorm_hold", comp(1), held);
    end
    in_valid = 1'b0;
    handshake("bp");

    // Back-to-back: normal after degenerate must clear the flag.
    a = '{0, 0, 0}; b = '{ONE, ONE, ONE}; c = '{ONE, ONE, ONE};
    run_tri("b2b_deg", a, b, c);
    handshake("b2b_deg");
    a = '{0, 0, 0}; b = '{2 * ONE, 0, 0}; c = '{0, 2 * ONE, 0};
    run_tri("b2b_norm", a, b, c);
    handshake("b2b_norm");

    // Reset while the square root is iterating.
    a = '{ONE, -ONE, 0}; b = '{3 * ONE, 2 * ONE, -ONE}; c = '{-2 * ONE, ONE, 5 * ONE};
    accept(a, b, c);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    for (int i = 0; i < 3; i++) check($sformatf("midrst_tnorm%0d", i), comp(i), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a = '{0, 0, 0}; b = '{ONE, 0, 0}; c = '{0, 3 * ONE, 4 * ONE};
    run_tri("after_rst", a, b, c);
    handshake("after_rst");

    // Random vertices within +-8.0.
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < 3; i++) begin
        a[i] = longint'($urandom_range(0, 1 << 26)) - (longint'(1) << 25);
        b[i] = longint'($urandom_range(0, 1 << 26)) - (longint'(1) << 25);
        c[i] = longint'($urandom_range(0, 1 << 26)) - (longint'(1) << 25);
      end
      run_tri($sformatf("rnd%0d", k), a, b, c);
      handshake($sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
